// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with optional operand forwarding and refresh (enabled by macro ID_EX_FWD_EN), plus issue counter
module id_ex_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [3:0]    in_opc,
  input  logic          flush,
  input  logic          exm_wr,
  input  logic [AW-1:0] exm_rd,
  input  logic [DW-1:0] exm_val,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] inpA,
  output logic [DW-1:0] inpB,
  output logic [3:0]    opc,
  output logic [AW-1:0] out_rd,
  output logic [15:0]   issue_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          st;
  logic [AW-1:0]   rs_q, rt_q, rd_q;
  logic            ui_q;
  logic [DW-1:0]   a_q, b_q, fa, fb;
  logic [3:0]      opc_q;
  logic [15:0]     cnt_q;
  logic            load, hold, issue;
  assign out_valid = (st == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready && !flush;
  assign hold      = out_valid && !out_ready && !flush;
  assign issue     = out_valid && out_ready && !flush;
  assign inpA      = fa;
  assign inpB      = fb;
  assign opc       = opc_q;
  assign out_rd    = rd_q;
  assign issue_cnt = cnt_q;
`ifdef ID_EX_FWD_EN
  // operand select: youngest producer (EX/MEM) first, then MEM/WB, then the registered value
  always_comb begin
    fa = (rs_q == '0) ? '0 :
         (exm_wr && exm_rd == rs_q) ? exm_val :
         (wb_wr && wb_rd == rs_q) ? wb_val : a_q;
    fb = ui_q ? b_q :
         (rt_q == '0) ? '0 :
         (exm_wr && exm_rd == rt_q) ? exm_val :
         (wb_wr && wb_rd == rt_q) ? wb_val : b_q;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_wr, exm_rd, exm_val, wb_wr, wb_rd, wb_val, rs_q, rt_q, ui_q};
  // operands come straight from the pipeline register; r0 was already zeroed at capture
  always_comb begin
    fa = a_q;
    fb = b_q;
  end
`endif
  // state, captured fields, stall-time operand refresh and issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= EMPTY;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      ui_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      opc_q <= '0;
      cnt_q <= '0;
    end else begin
      st <= (load || hold) ? FULL : EMPTY;
      if (load) begin
        rs_q  <= in_rs;
        rt_q  <= in_rt;
        rd_q  <= in_rd;
        ui_q  <= in_use_imm;
        a_q   <= (in_rs == '0) ? '0 : in_rs_val;
        b_q   <= in_use_imm ? in_imm : (in_rt == '0) ? '0 : in_rt_val;
        opc_q <= in_opc;
      end else if (hold) begin
        a_q <= fa;
        b_q <= fb;
      end
      if (issue) cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench with scoreboard for id_ex_stage (forwarding expectations follow ID_EX_FWD_EN)
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int AW = 3;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [AW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [DW-1:0] in_rs_val = '0, in_rt_val = '0, in_imm = '0;
  logic          in_use_imm = 1'b0;
  logic [3:0]    in_opc = '0;
  logic          flush = 1'b0;
  logic          exm_wr = 1'b0, wb_wr = 1'b0;
  logic [AW-1:0] exm_rd = '0, wb_rd = '0;
  logic [DW-1:0] exm_val = '0, wb_val = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] inpA, inpB;
  logic [3:0]    opc;
  logic [AW-1:0] out_rd;
  logic [15:0]   issue_cnt;
  int checks = 0, errors = 0;
  bit sb_en = 1'b1;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [3:0] op; logic [2:0] rd;} exp_t;
  exp_t q[$];
  exp_t e;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_opc(in_opc), .flush(flush),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_val(exm_val),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .inpA(inpA), .inpB(inpB), .opc(opc), .out_rd(out_rd), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                    input logic [15:0] rsv, input logic [15:0] rtv, input logic [15:0] imm,
                    input logic ui, input logic [3:0] op);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_use_imm = ui; in_opc = op;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op, input logic [2:0] rd);
    exp_t x;
    x.a = a; x.b = b; x.op = op; x.rd = rd;
    q.push_back(x);
  endtask

  // scoreboard: every handshake on the ALU side must match the oldest expected instruction
  always @(negedge clk) begin
    if (sb_en && rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("sb_inpA", inpA, e.a);
        chk("sb_inpB", inpB, e.b);
        chk("sb_opc", opc, e.op);
        chk("sb_rd", out_rd, e.rd);
      end
    end
  end

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", issue_cnt, 0);
    chk("rst_inpA", inpA, 0);
    chk("rst_inpB", inpB, 0);
    chk("rst_opc", opc, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    // basic load and issue
    out_ready = 1'b1;
    ld(1, 2, 4, 16'd8, 16'd2, 0, 0, 0);
    push(16'd8, 16'd2, 0, 4);
    tick;
    chk("basic_valid", out_valid, 1);
    chk("basic_inpA", inpA, 16'd8);
    chk("basic_inpB", inpB, 16'd2);
    in_valid = 1'b0;
    tick;
    chk("basic_empty", out_valid, 0);
    chk("basic_cnt", issue_cnt, 1);
    // exm overrides wb on a held instruction, and the refresh survives producer retirement
    out_ready = 1'b0;
    ld(3, 0, 5, 16'h0011, 0, 0, 0, 2);
    tick;
    in_valid = 1'b0;
    exm_wr = 1'b1; exm_rd = 3; exm_val = 16'h0020;
    wb_wr = 1'b1; wb_rd = 3; wb_val = 16'h0005;
    #1;
    chk("fwd_prio", inpA, FWD ? 16'h0020 : 16'h0011);
    chk("fwd_rt0", inpB, 0);
    tick;
    exm_wr = 1'b0; wb_wr = 1'b0;
    #1;
    chk("fwd_kept", inpA, FWD ? 16'h0020 : 16'h0011);
    push(FWD ? 16'h0020 : 16'h0011, 0, 2, 5);
    out_ready = 1'b1;
    tick;
    chk("fwd_empty", out_valid, 0);
    chk("fwd_cnt", issue_cnt, 2);
    // back-pressure: stable outputs, in_ready low despite in_valid, then a one-cycle wb refresh
    out_ready = 1'b0;
    ld(2, 6, 1, 16'h0100, 16'h0007, 0, 0, 3);
    tick;
    ld(5, 5, 5, 16'hAAAA, 16'hBBBB, 0, 0, 4);
    repeat (3) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_inpA", inpA, 16'h0100);
      chk("stall_inpB", inpB, 16'h0007);
      chk("stall_opc", opc, 3);
      chk("stall_rd", out_rd, 1);
      tick;
    end
    wb_wr = 1'b1; wb_rd = 6; wb_val = 16'h0042;
    tick;
    wb_wr = 1'b0; in_valid = 1'b0;
    #1;
    chk("refresh_inpB", inpB, FWD ? 16'h0042 : 16'h0007);
    push(16'h0100, FWD ? 16'h0042 : 16'h0007, 3, 1);
    out_ready = 1'b1;
    tick;
    chk("refresh_cnt", issue_cnt, 3);
    chk("refresh_empty", out_valid, 0);
    // flush beats a same-cycle load, and kills a held branch without counting it
    flush = 1'b1;
    ld(1, 0, 3, 16'h0009, 0, 0, 0, 9);
    tick;
    chk("flush_load_valid", out_valid, 0);
    chk("flush_load_cnt", issue_cnt, 3);
    flush = 1'b0; out_ready = 1'b0;
    tick;
    chk("branch_valid", out_valid, 1);
    chk("branch_opc", opc, 9);
    flush = 1'b1; out_ready = 1'b1;
    ld(1, 0, 4, 16'h0010, 0, 0, 0, 1);
    tick;
    chk("flush_held_valid", out_valid, 0);
    chk("flush_held_cnt", issue_cnt, 3);
    flush = 1'b0; in_valid = 1'b0;
    // immediate blocks rt forwarding; r0 source stays zero even with an r0 "hit"
    out_ready = 1'b0;
    ld(0, 3, 7, 16'h0055, 16'h0077, 16'h0002, 1, 1);
    tick;
    in_valid = 1'b0;
    exm_wr = 1'b1; exm_rd = 3; exm_val = 16'h0099;
    #1;
    chk("imm_inpB", inpB, 16'h0002);
    exm_rd = 0;
    wb_wr = 1'b1; wb_rd = 0; wb_val = 16'h0066;
    #1;
    chk("r0_inpA", inpA, 0);
    tick;
    exm_wr = 1'b0; wb_wr = 1'b0;
    #1;
    chk("r0_refresh_inpA", inpA, 0);
    chk("imm_refresh_inpB", inpB, 16'h0002);
    push(0, 16'h0002, 1, 7);
    out_ready = 1'b1;
    tick;
    chk("imm_cnt", issue_cnt, 4);
    // back-to-back loads while issuing keep the stage FULL
    ld(1, 2, 2, 16'h1234, 16'h4321, 0, 0, 9);
    push(16'h1234, 16'h4321, 9, 2);
    tick;
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_opc0", opc, 9);
    ld(4, 0, 6, 16'hBEEF, 0, 0, 0, 4'hF);
    push(16'hBEEF, 0, 4'hF, 6);
    tick;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_opc1", opc, 4'hF);
    chk("b2b_rd1", out_rd, 6);
    in_valid = 1'b0;
    tick;
    chk("b2b_empty", out_valid, 0);
    chk("b2b_cnt", issue_cnt, 6);
    // asynchronous reset while FULL, then first capture on the first edge after release
    out_ready = 1'b0;
    ld(1, 0, 3, 16'h0077, 0, 0, 0, 5);
    tick;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", issue_cnt, 0);
    chk("async_rst_inpA", inpA, 0);
    chk("async_rst_opc", opc, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    ld(2, 3, 4, 16'h0031, 16'h0013, 0, 0, 6);
    push(16'h0031, 16'h0013, 6, 4);
    tick;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_inpA", inpA, 16'h0031);
    in_valid = 1'b0;
    tick;
    chk("post_rst_cnt", issue_cnt, 1);
    // issue counter wrap
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    sb_en = 1'b0;
    ld(1, 0, 1, 16'h0001, 0, 0, 0, 0);
    tick;
    repeat (65535) tick;
    chk("cnt_ffff", issue_cnt, 16'hFFFF);
    tick;
    chk("cnt_wrap", issue_cnt, 0);
    in_valid = 1'b0;
    tick;
    chk("cnt_after_wrap", issue_cnt, 1);
    chk("final_empty", out_valid, 0);
    chk("sb_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
